// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU command sequencer:
//   - seq_state_e : sequencer FSM states (IDLE, SETTLE, RESP)
//   - CMD_*       : ALU command encodings understood by the sequencer
//   - ERR_*       : bit positions inside the 2-bit ALU error vector
//   - is_legal_cmd: true for the commands the ALU actually implements
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } seq_state_e;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_MUL = 4'd3;
  localparam logic [3:0] CMD_DIV = 4'd4;
  localparam logic [3:0] CMD_MOD = 4'd5;

  localparam int ERR_DBZ = 1;
  localparam int ERR_OVF = 0;

  // Legal commands form one contiguous range, so a range check is enough.
  function automatic logic is_legal_cmd(input logic [3:0] cmd);
    return (cmd >= CMD_ADD) && (cmd <= CMD_MOD);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// alu_cmd_sequencer_if
// Host-side request/response channels of the ALU command sequencer.
//   Request : req_valid/req_ready handshake carrying req_a, req_b (16 bit)
//             and req_cmd (4 bit).
//   Response: rsp_valid/rsp_ready handshake carrying rsp_result (32 bit),
//             rsp_error (2 bit: bit1 divide-by-zero, bit0 overflow) and
//             rsp_illegal (unsupported command).
// Modports:
//   master - the host / test driver that issues requests
//   slave  - the sequencer that services them
interface alu_cmd_sequencer_if;

  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [3:0]  req_cmd;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [1:0]  rsp_error;
  logic        rsp_illegal;

  modport master (
    output req_valid, req_a, req_b, req_cmd, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_error, rsp_illegal
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cmd, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_error, rsp_illegal
  );

endinterface

// File: rtl/alu_seq_stats.sv
// alu_seq_stats
// Saturating operation / error counters for the ALU command sequencer.
// Only instantiated when ALU_SEQ_STATS_EN is defined.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   rsp_fire      - a response handshake happens this cycle
//   rsp_err_flag  - the response being handed over carries an error/illegal
//   stat_ops      - completed response handshakes (saturates at 16'hFFFF)
//   stat_errs     - completed handshakes that reported a problem (saturates)
module alu_seq_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        rsp_fire,
  input  logic        rsp_err_flag,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_errs
);

  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_errs_q, stat_errs_d;

  // Both counters stick at all-ones instead of wrapping so a long run
  // never reports a misleadingly small number.
  always_comb begin
    stat_ops_d  = stat_ops_q;
    stat_errs_d = stat_errs_q;
    if (rsp_fire) begin
      if (stat_ops_q != 16'hFFFF) stat_ops_d = stat_ops_q + 16'd1;
      if (rsp_err_flag && (stat_errs_q != 16'hFFFF)) stat_errs_d = stat_errs_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_ops_q  <= 16'd0;
      stat_errs_q <= 16'd0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_errs_q <= stat_errs_d;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_errs = stat_errs_q;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Initiator for the combinational ALU breadboard. Accepts one request,
// drives the ALU inputs from registers, waits SETTLE_CYCLES clocks for the
// ALU to settle, captures and formats the result, then returns it over a
// response handshake.
// Parameters:
//   SETTLE_CYCLES - clocks between driving the ALU and sampling it (1..15)
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   host (slave)      - request/response channels (alu_cmd_sequencer_if)
//   alu_a/alu_b       - registered operands to the ALU
//   alu_cmd           - registered command to the ALU (0 when idle)
//   alu_result        - ALU result input
//   alu_error         - ALU error input (bit1 divide-by-zero, bit0 overflow)
//   stat_ops/stat_errs- handshake counters, present only when the
//                       ALU_SEQ_STATS_EN macro is defined
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst,
  alu_cmd_sequencer_if.slave  host,
  output logic [15:0]         alu_a,
  output logic [15:0]         alu_b,
  output logic [3:0]          alu_cmd,
  input  logic [31:0]         alu_result,
  input  logic [1:0]          alu_error
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [15:0]         stat_errs
`endif
);

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  seq_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] alu_a_q, alu_a_d;
  logic [15:0] alu_b_q, alu_b_d;
  logic [3:0]  alu_cmd_q, alu_cmd_d;
  logic        illegal_q, illegal_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_result_q, rsp_result_d;
  logic [1:0]  rsp_error_q, rsp_error_d;
  logic        rsp_illegal_q, rsp_illegal_d;
  logic        rsp_fire;

  assign rsp_fire = rsp_valid_q && host.rsp_ready;

  // Next-state logic. An illegal command still spends one cycle in SETTLE
  // (counter forced to 0) so its response appears one edge after
  // acceptance, while the ALU channel stays grounded the whole time.
  // req_ready and rsp_valid are registered copies of "next state is IDLE /
  // RESP", which keeps them glitch-free and makes req_ready rise on the
  // first edge after reset.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_cmd_d     = alu_cmd_q;
    illegal_d     = illegal_q;
    rsp_result_d  = rsp_result_q;
    rsp_error_d   = rsp_error_q;
    rsp_illegal_d = rsp_illegal_q;

    unique case (state_q)
      IDLE: begin
        if (host.req_valid && req_ready_q) begin
          state_d = SETTLE;
          if (is_legal_cmd(host.req_cmd)) begin
            alu_a_d   = host.req_a;
            alu_b_d   = host.req_b;
            alu_cmd_d = host.req_cmd;
            illegal_d = 1'b0;
            cnt_d     = CNT_LOAD;
          end else begin
            illegal_d = 1'b1;
            cnt_d     = 4'd0;
          end
        end
      end

      SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (illegal_q) begin
            rsp_result_d  = 32'd0;
            rsp_error_d   = 2'b00;
            rsp_illegal_d = 1'b1;
          end else begin
            rsp_illegal_d = 1'b0;
            rsp_result_d  = alu_result;
            rsp_error_d   = 2'b00;
            // Add/sub are 16-bit operations: drop whatever the ALU puts in
            // the upper half. Overflow only means something for add/sub and
            // divide-by-zero only for div/mod.
            unique case (alu_cmd_q)
              CMD_ADD, CMD_SUB: begin
                rsp_result_d         = {16'h0000, alu_result[15:0]};
                rsp_error_d[ERR_OVF] = alu_error[ERR_OVF];
              end
              CMD_DIV, CMD_MOD: begin
                rsp_error_d[ERR_DBZ] = alu_error[ERR_DBZ];
              end
              default: begin
                rsp_error_d = 2'b00;
              end
            endcase
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP: begin
        if (rsp_fire) begin
          state_d   = IDLE;
          alu_a_d   = 16'd0;
          alu_b_d   = 16'd0;
          alu_cmd_d = 4'd0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // State registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      alu_a_q       <= 16'd0;
      alu_b_q       <= 16'd0;
      alu_cmd_q     <= 4'd0;
      illegal_q     <= 1'b0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= 32'd0;
      rsp_error_q   <= 2'b00;
      rsp_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_cmd_q     <= alu_cmd_d;
      illegal_q     <= illegal_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_result_q  <= rsp_result_d;
      rsp_error_q   <= rsp_error_d;
      rsp_illegal_q <= rsp_illegal_d;
    end
  end

  assign host.req_ready   = req_ready_q;
  assign host.rsp_valid   = rsp_valid_q;
  assign host.rsp_result  = rsp_result_q;
  assign host.rsp_error   = rsp_error_q;
  assign host.rsp_illegal = rsp_illegal_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_cmd          = alu_cmd_q;

`ifdef ALU_SEQ_STATS_EN
  alu_seq_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .rsp_fire     (rsp_fire),
    .rsp_err_flag ((rsp_error_q != 2'b00) || rsp_illegal_q),
    .stat_ops     (stat_ops),
    .stat_errs    (stat_errs)
  );
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer
// Directed bench for alu_cmd_sequencer with SETTLE_CYCLES = 2. A small
// behavioural ALU drives alu_result/alu_error from the sequencer's ALU
// outputs; it deliberately puts junk in the upper half of add/sub results
// and can OR extra error bits in, so formatting and masking are visible.
// Define ALU_SEQ_STATS_EN to also check the statistics counters.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_cmd_sequencer_if bus ();

  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_cmd;
  logic [31:0] alu_result;
  logic [1:0]  alu_error;
  logic [15:0] junk_hi;
  logic [1:0]  force_err;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops;
  logic [15:0] stat_errs;
`endif

  int testCount = 0;
  int failCount = 0;

  alu_cmd_sequencer #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .host       (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cmd    (alu_cmd),
    .alu_result (alu_result),
    .alu_error  (alu_error)
`ifdef ALU_SEQ_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_errs  (stat_errs)
`endif
  );

  // Behavioural ALU: signed 16-bit overflow for add/sub, product wider than
  // 16 bits flags overflow for mul, zero divisor flags divide-by-zero.
  logic [15:0] sum16;
  logic [15:0] dif16;
  logic [31:0] prod32;
  assign sum16  = alu_a + alu_b;
  assign dif16  = alu_a - alu_b;
  assign prod32 = 32'(alu_a) * 32'(alu_b);

  always_comb begin
    alu_result = 32'd0;
    alu_error  = 2'b00;
    case (alu_cmd)
      4'd1: begin
        alu_result   = {junk_hi, sum16};
        alu_error[0] = (alu_a[15] == alu_b[15]) && (sum16[15] != alu_a[15]);
      end
      4'd2: begin
        alu_result   = {junk_hi, dif16};
        alu_error[0] = (alu_a[15] != alu_b[15]) && (dif16[15] != alu_a[15]);
      end
      4'd3: begin
        alu_result   = prod32;
        alu_error[0] = |prod32[31:16];
      end
      4'd4: begin
        if (alu_b == 16'd0) begin
          alu_result = 32'hFFFF_FFFF;
          alu_error  = 2'b10;
        end else begin
          alu_result = {16'h0000, alu_a / alu_b};
        end
      end
      4'd5: begin
        if (alu_b == 16'd0) begin
          alu_result = {16'h0000, alu_a};
          alu_error  = 2'b10;
        end else begin
          alu_result = {16'h0000, alu_a % alu_b};
        end
      end
      default: begin
        alu_result = 32'd0;
        alu_error  = 2'b00;
      end
    endcase
    alu_error = alu_error | force_err;
  end

  // One clock step; sampling and driving happen 1 ns after the rising edge.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  // Single comparison point: counts and reports through an immediate assertion.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Offers a request and waits (bounded) until it is accepted. Returns just
  // after the acceptance edge with req_valid dropped.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] cmd);
    int guard;
    guard         = 0;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cmd   = cmd;
    bus.req_valid = 1'b1;
    while ((bus.req_ready !== 1'b1) && (guard < 20)) begin
      stepClk();
      guard++;
    end
    checkOutput("req_ready_wait", 32'(bus.req_ready), 32'd1);
    stepClk();
    bus.req_valid = 1'b0;
  endtask

  // Counts edges from acceptance until rsp_valid, then checks the payload.
  task automatic waitResponse(input string tag, input int expLat,
                              input logic [31:0] expRes, input logic [1:0] expErr,
                              input logic expIll);
    int lat;
    lat = 0;
    while ((bus.rsp_valid !== 1'b1) && (lat < 20)) begin
      stepClk();
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_result"}, bus.rsp_result, expRes);
    checkOutput({tag, "_error"}, 32'(bus.rsp_error), 32'(expErr));
    checkOutput({tag, "_illegal"}, 32'(bus.rsp_illegal), 32'(expIll));
  endtask

  // Takes the response (rsp_ready assumed high) and checks the return to IDLE.
  task automatic finishResponse(input string tag);
    stepClk();
    checkOutput({tag, "_rsp_valid_clr"}, 32'(bus.rsp_valid), 32'd0);
    checkOutput({tag, "_req_ready_set"}, 32'(bus.req_ready), 32'd1);
    checkOutput({tag, "_alu_cmd_clr"}, 32'(alu_cmd), 32'd0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_a     = 16'd0;
    bus.req_b     = 16'd0;
    bus.req_cmd   = 4'd0;
    bus.rsp_ready = 1'b1;
    junk_hi       = 16'hDEAD;
    force_err     = 2'b00;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("rst_rsp_result", bus.rsp_result, 32'd0);
    checkOutput("rst_rsp_error", 32'(bus.rsp_error), 32'd0);
    checkOutput("rst_rsp_illegal", 32'(bus.rsp_illegal), 32'd0);
    checkOutput("rst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("rst_alu_b", 32'(alu_b), 32'd0);
    checkOutput("rst_alu_cmd", 32'(alu_cmd), 32'd0);
`ifdef ALU_SEQ_STATS_EN
    checkOutput("rst_stat_ops", 32'(stat_ops), 32'd0);
    checkOutput("rst_stat_errs", 32'(stat_errs), 32'd0);
`endif
    rst = 1'b0;
    checkOutput("ready_before_edge", 32'(bus.req_ready), 32'd0);
    stepClk();
    checkOutput("ready_after_edge", 32'(bus.req_ready), 32'd1);

    // Basic operations, a=249 b=69
    applyStimulus(16'd249, 16'd69, 4'd1);
    checkOutput("add_alu_cmd", 32'(alu_cmd), 32'd1);
    checkOutput("add_alu_a", 32'(alu_a), 32'd249);
    checkOutput("add_alu_b", 32'(alu_b), 32'd69);
    checkOutput("add_req_ready_busy", 32'(bus.req_ready), 32'd0);
    waitResponse("add", 2, 32'd318, 2'b00, 1'b0);
    finishResponse("add");

    applyStimulus(16'd249, 16'd69, 4'd2);
    waitResponse("sub", 2, 32'd180, 2'b00, 1'b0);
    finishResponse("sub");

    applyStimulus(16'd249, 16'd69, 4'd3);
    waitResponse("mul", 2, 32'd17181, 2'b00, 1'b0);
    finishResponse("mul");

    applyStimulus(16'd249, 16'd69, 4'd4);
    waitResponse("div", 2, 32'd3, 2'b00, 1'b0);
    finishResponse("div");
`ifdef ALU_SEQ_STATS_EN
    checkOutput("stats4_ops", 32'(stat_ops), 32'd4);
    checkOutput("stats4_errs", 32'(stat_errs), 32'd0);
`endif

    // Overflow and upper-half masking
    applyStimulus(16'h7D00, 16'h2001, 4'd1);
    waitResponse("ovf_add", 2, 32'h0000_9D01, 2'b01, 1'b0);
    finishResponse("ovf_add");

    applyStimulus(16'h7D00, 16'h2001, 4'd3);
    waitResponse("ovf_mul", 2, 32'h0FA0_7D00, 2'b00, 1'b0);
    finishResponse("ovf_mul");

    // Divide by zero, and a dbz bit forced onto an add is masked
    applyStimulus(16'd100, 16'd0, 4'd4);
    waitResponse("dbz_div", 2, 32'hFFFF_FFFF, 2'b10, 1'b0);
    finishResponse("dbz_div");

    force_err = 2'b10;
    applyStimulus(16'd100, 16'd0, 4'd1);
    waitResponse("dbz_add", 2, 32'd100, 2'b00, 1'b0);
    finishResponse("dbz_add");

    // Forced error bits: sub keeps only overflow, mod drops overflow
    force_err = 2'b11;
    applyStimulus(16'd249, 16'd69, 4'd2);
    waitResponse("mask_sub", 2, 32'd180, 2'b01, 1'b0);
    finishResponse("mask_sub");

    force_err = 2'b01;
    applyStimulus(16'd249, 16'd69, 4'd5);
    waitResponse("mask_mod", 2, 32'd42, 2'b00, 1'b0);
    finishResponse("mask_mod");
    force_err = 2'b00;

    // Illegal commands
    applyStimulus(16'd249, 16'd69, 4'd9);
    checkOutput("ill9_alu_cmd_settle", 32'(alu_cmd), 32'd0);
    waitResponse("ill9", 1, 32'd0, 2'b00, 1'b1);
    checkOutput("ill9_alu_cmd_resp", 32'(alu_cmd), 32'd0);
    checkOutput("ill9_alu_a_resp", 32'(alu_a), 32'd0);
    finishResponse("ill9");

    applyStimulus(16'd5, 16'd6, 4'd0);
    waitResponse("ill0", 1, 32'd0, 2'b00, 1'b1);
    finishResponse("ill0");

    // Request inputs changing during SETTLE are ignored
    applyStimulus(16'd249, 16'd69, 4'd3);
    bus.req_valid = 1'b1;
    bus.req_a     = 16'h1111;
    bus.req_b     = 16'h2222;
    bus.req_cmd   = 4'd1;
    waitResponse("ignore", 2, 32'd17181, 2'b00, 1'b0);
    checkOutput("ignore_alu_a", 32'(alu_a), 32'd249);
    checkOutput("ignore_alu_cmd", 32'(alu_cmd), 32'd3);
    bus.req_valid = 1'b0;
    finishResponse("ignore");

    // Backpressure: hold rsp_ready low for 5 cycles
    bus.rsp_ready = 1'b0;
    applyStimulus(16'd249, 16'd69, 4'd1);
    waitResponse("bp", 2, 32'd318, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      stepClk();
      checkOutput("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      checkOutput("bp_hold_result", bus.rsp_result, 32'd318);
      checkOutput("bp_hold_alu_cmd", 32'(alu_cmd), 32'd1);
      checkOutput("bp_hold_alu_a", 32'(alu_a), 32'd249);
      checkOutput("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    finishResponse("bp");
    checkOutput("bp_alu_a_clr", 32'(alu_a), 32'd0);
`ifdef ALU_SEQ_STATS_EN
    checkOutput("stats14_ops", 32'(stat_ops), 32'd14);
    checkOutput("stats14_errs", 32'(stat_errs), 32'd5);
`endif

    // Reset one cycle into SETTLE
    applyStimulus(16'd249, 16'd69, 4'd2);
    stepClk();
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    checkOutput("midrst_rsp_result", bus.rsp_result, 32'd0);
    checkOutput("midrst_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("midrst_alu_a", 32'(alu_a), 32'd0);
    checkOutput("midrst_alu_cmd", 32'(alu_cmd), 32'd0);
    stepClk();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      stepClk();
      checkOutput("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    checkOutput("midrst_idle_ready", 32'(bus.req_ready), 32'd1);
`ifdef ALU_SEQ_STATS_EN
    checkOutput("midrst_stat_ops", 32'(stat_ops), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
